datapath_regfile_lsu: RTL and testbench
=======================================

Name: datapath_regfile_lsu

Overview:
- Parametrised successor to the core datapath's register file.
- Generic width/depth register array; register 0 is the program counter with built-in auto-increment; two prioritised write ports.
- Adds a single-outstanding load unit with a memory request/grant/response handshake, a busy scoreboard and a read-hazard stall output.
- Sits between the decoder/ALU and the data-memory port. The ALU consumes the read ports and drives the write ports.

Parameters:
- DATA_W, 32, register and data width.
- AW, 4, register address width; NREGS = 2**AW.
- INIT_PC, 16, reset value of register 0.
- PC_STEP, 4, increment applied to register 0 on pc_inc.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_en  in  4  read-enable per port A..D; used only for hazard detection.
- rd_addr_a/b/c/d  in  AW each  read addresses.
- rd_data_a/b/c/d  out  DATA_W each  combinational read data.
- pc_read_en  in  1  when 0, register 0 reads as 0 on all read ports.
- pc  out  DATA_W  current register 0 value, unmasked.
- pc_inc  in  1  advance PC by PC_STEP.
- w1_en, w2_en  in  1 each  write enables.
- w1_addr, w2_addr  in  AW each  write addresses.
- w1_data, w2_data  in  DATA_W each  write data.
- ld_issue  in  1  start a load.
- ld_dest  in  AW  load destination register.
- ld_addr  in  DATA_W  load memory address.
- ld_ready  out  1  load unit idle; ld_issue is accepted this cycle.
- mem_req  out  1  memory request valid.
- mem_addr  out  DATA_W  request address, held stable while mem_req=1.
- mem_gnt  in  1  memory accepts the request.
- mem_rvalid  in  1  response data valid.
- mem_rdata  in  DATA_W  response data.
- stall  out  1  a read port with rd_en set targets the pending load destination.
- wr_conflict  out  1  registered one-cycle pulse: a write was dropped.

Behaviour:
- Reset (async assert, sync release):
  - All registers 0; register 0 = INIT_PC.
  - FSM IDLE; mem_req=0; mem_addr=0; wr_conflict=0; scoreboard clear.
  - ld_ready=1 and stall=0 once reset is released.
- Reads: combinational, zero latency; no write-to-read bypass (new value visible the cycle after the edge).
- FSM states: IDLE, REQ, WAIT.
  - IDLE: ld_ready=1. ld_issue latches ld_dest/ld_addr, sets the busy flag for ld_dest, goes to REQ.
  - REQ: mem_req=1, mem_addr=latched address.
    - mem_gnt && !mem_rvalid -> WAIT.
    - mem_gnt && mem_rvalid in the same cycle -> write mem_rdata, clear busy, go to IDLE.
    - mem_rvalid without mem_gnt is ignored.
  - WAIT: mem_req=0. mem_rvalid -> write mem_rdata to the latched dest, clear busy, go to IDLE.
  - ld_issue outside IDLE is ignored; no back-to-back issue on the completion cycle (ld_ready=0 that cycle).
- Per-register write priority each edge, highest first:
  1. load return
  2. w2
  3. w1
  4. pc_inc (register 0 only)
- Write conflicts:
  - A w1/w2 write to the currently busy register is dropped and wr_conflict pulses the next cycle. This includes the completion cycle.
  - w1 and w2 to the same address: w2 wins, no conflict flagged.
- PC:
  - If no explicit write hits register 0 and pc_inc=1, then reg0 <= reg0 + PC_STEP, modulo 2**DATA_W (wraps).
  - An explicit write or load return to register 0 overrides pc_inc; the increment is lost.
- stall = busy && OR over ports of (rd_en[i] && rd_addr_i == pending dest). Combinational; deasserts the cycle after the load-return edge.
- Reset mid-load: FSM returns to IDLE, busy clears, mem_req drops immediately; a late mem_rvalid is ignored.

Test Plan:
- Reset release -> pc=16, rd_data_a at addr 0 with pc_read_en=0 -> 0; with pc_read_en=1 -> 16. Three pc_inc cycles -> pc=28.
- w1 (addr 5, 0xAAAA) and w2 (addr 5, 0x5555) in the same cycle -> reg5=0x5555, wr_conflict=0.
- ld_issue dest 3, addr 0x100; gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF:
  - mem_addr=0x100 throughout REQ.
  - reg3=0xDEADBEEF.
  - stall=1 while rd_en[0] and rd_addr_a=3 during the load.
  - ld_ready back to 1 the cycle after the data write.
- w1 to reg3 while the load to reg3 is pending -> write dropped, wr_conflict pulses 1 cycle, reg3 = load data afterwards.
- pc = 2**32-4 with pc_inc -> pc=0. Same-cycle pc_inc and w1 to reg0 = 0x40 -> pc=0x40.
- mem_gnt and mem_rvalid in the same REQ cycle -> data written, FSM returns to IDLE. Separately, reset asserted in WAIT then a late rvalid -> no register change, mem_req=0.

Source files
------------

// File: rtl/datapath_regfile_lsu.sv
// datapath_regfile_lsu
//
// Purpose: register file for the core datapath with a built-in program
// counter (register 0) and a single-outstanding load unit that talks to the
// data-memory port. Each register may be written per clock by a load return,
// by write port 2, by write port 1, or (register 0 only) by the PC increment,
// in that order of priority. A busy scoreboard marks the pending load
// destination: ALU writes to it are dropped and flagged, and reads of it
// raise stall.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   rd_en[3:0]                   per-port read enables (hazard detection only)
//   rd_addr_a..d / rd_data_a..d  four combinational read ports
//   pc_read_en                   0 masks register 0 to zero on the read ports
//   pc                           unmasked register 0
//   pc_inc                       advance register 0 by PC_STEP
//   w1_*/w2_*                    ALU write ports (w2 has priority)
//   ld_issue/ld_dest/ld_addr     load request from the decoder
//   ld_ready                     load unit idle, ld_issue accepted
//   mem_req/mem_addr/mem_gnt     memory request handshake
//   mem_rvalid/mem_rdata         memory response
//   stall                        enabled read port targets the pending load
//   wr_conflict                  one-cycle pulse: an ALU write was dropped
module datapath_regfile_lsu #(
    parameter int DATA_W  = 32,
    parameter int AW      = 4,
    parameter int INIT_PC = 16,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        rd_en,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    input  logic [AW-1:0]     rd_addr_c,
    input  logic [AW-1:0]     rd_addr_d,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_c,
    output logic [DATA_W-1:0] rd_data_d,
    input  logic              pc_read_en,
    output logic [DATA_W-1:0] pc,
    input  logic              pc_inc,
    input  logic              w1_en,
    input  logic [AW-1:0]     w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic              w2_en,
    input  logic [AW-1:0]     w2_addr,
    input  logic [DATA_W-1:0] w2_data,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_dest,
    input  logic [DATA_W-1:0] ld_addr,
    output logic              ld_ready,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wr_conflict
);

    localparam int NREGS = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [AW-1:0]       dest_q;
    logic [DATA_W-1:0]   addr_q;
    logic [NREGS-1:0]    busy;
    logic                issue_ok;
    logic                ret_fire;
    logic                w1_ok;
    logic                w2_ok;

    // Register 0 reads as zero on the read ports unless pc_read_en is set.
    function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] a);
        if (a == '0 && !pc_read_en) begin
            return '0;
        end
        return regs[a];
    endfunction

    assign rd_data_a = read_port(rd_addr_a);
    assign rd_data_b = read_port(rd_addr_b);
    assign rd_data_c = read_port(rd_addr_c);
    assign rd_data_d = read_port(rd_addr_d);
    assign pc        = regs[0];
    assign mem_addr  = addr_q;

    // Only one load can be outstanding, so at most one busy bit is ever set.
    assign stall = |(rd_en & {busy[rd_addr_d], busy[rd_addr_c],
                              busy[rd_addr_b], busy[rd_addr_a]});

    // ALU writes into the pending load destination are dropped; that
    // includes the completion cycle, where the load data takes the register.
    assign w1_ok = w1_en && !busy[w1_addr];
    assign w2_ok = w2_en && !busy[w2_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        mem_req    = 1'b0;
        issue_ok   = 1'b0;
        ret_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                ld_ready = 1'b1;
                if (ld_issue) begin
                    issue_ok   = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                // A response without a grant is not ours yet and is ignored.
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        ret_fire   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    ret_fire   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dest_q <= '0;
            addr_q <= '0;
        end else if (issue_ok) begin
            dest_q <= ld_dest;
            addr_q <= ld_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (issue_ok) begin
            busy          <= '0;
            busy[ld_dest] <= 1'b1;
        end else if (ret_fire) begin
            busy <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= (w1_en && busy[w1_addr]) || (w2_en && busy[w2_addr]);
        end
    end

    // Per-register priority: load return, w2, w1, then PC increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs[0] <= DATA_W'(INIT_PC);
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ret_fire && dest_q == AW'(i)) begin
                    regs[i] <= mem_rdata;
                end else if (w2_ok && w2_addr == AW'(i)) begin
                    regs[i] <= w2_data;
                end else if (w1_ok && w1_addr == AW'(i)) begin
                    regs[i] <= w1_data;
                end else if (i == 0 && pc_inc) begin
                    regs[i] <= regs[i] + DATA_W'(PC_STEP);
                end
            end
        end
    end

endmodule

// File: tb/tb_datapath_regfile_lsu.sv
// Testbench for datapath_regfile_lsu: reset state, PC increment and wrap,
// dual write priority, load handshake with stall and write conflicts,
// grant-with-response, and reset during an outstanding load.
module tb_datapath_regfile_lsu;

    localparam int DATA_W = 32;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [3:0]        rd_en;
    logic [AW-1:0]     rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d;
    logic [DATA_W-1:0] rd_data_a, rd_data_b, rd_data_c, rd_data_d;
    logic              pc_read_en;
    logic [DATA_W-1:0] pc;
    logic              pc_inc;
    logic              w1_en, w2_en;
    logic [AW-1:0]     w1_addr, w2_addr;
    logic [DATA_W-1:0] w1_data, w2_data;
    logic              ld_issue;
    logic [AW-1:0]     ld_dest;
    logic [DATA_W-1:0] ld_addr;
    logic              ld_ready;
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_gnt, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              wr_conflict;

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_val;

    always #5 clk = ~clk;

    datapath_regfile_lsu #(
        .DATA_W(DATA_W), .AW(AW), .INIT_PC(16), .PC_STEP(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_addr_c(rd_addr_c), .rd_addr_d(rd_addr_d),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_data_c(rd_data_c), .rd_data_d(rd_data_d),
        .pc_read_en(pc_read_en), .pc(pc), .pc_inc(pc_inc),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .w2_en(w2_en), .w2_addr(w2_addr), .w2_data(w2_data),
        .ld_issue(ld_issue), .ld_dest(ld_dest), .ld_addr(ld_addr),
        .ld_ready(ld_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .wr_conflict(wr_conflict)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en      = 4'b0000;
        pc_inc     = 1'b0;
        w1_en      = 1'b0;
        w2_en      = 1'b0;
        ld_issue   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = '0; rd_addr_d = '0;
        w1_addr = '0; w2_addr = '0; w1_data = '0; w2_data = '0;
        ld_dest = '0; ld_addr = '0; mem_rdata = '0; pc_read_en = 1'b0;
        repeat (2) step();
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req_held: got %b expected 0", mem_req); end
        #2 reset_n = 1'b1;
        step();
        checks++;
        if (pc !== 32'd16) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'd16); end
        checks++;
        if (ld_ready !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || wr_conflict !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got ld_ready=%b stall=%b mem_req=%b wr_conflict=%b expected 1 0 0 0",
                     ld_ready, stall, mem_req, wr_conflict);
        end
        checks++;
        if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        rd_addr_a = 4'd0; rd_addr_b = 4'd5;
        #1;
        checks++;
        if (rd_data_a !== 32'd0) begin errors++; $display("[TB] FAIL pc_masked_read: got %h expected 0", rd_data_a); end
        checks++;
        if (rd_data_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_reg5: got %h expected 0", rd_data_b); end
        pc_read_en = 1'b1;
        #1;
        checks++;
        if (rd_data_a !== 32'd16) begin errors++; $display("[TB] FAIL pc_unmasked_read: got %h expected %h", rd_data_a, 32'd16); end
    endtask

    task automatic test_pc_inc();
        exp_q.push_back(32'd28);
        pc_inc = 1'b1;
        repeat (3) step();
        pc_inc = 1'b0;
        step();
        exp_val = exp_q.pop_front();
        checks++;
        if (pc !== exp_val) begin errors++; $display("[TB] FAIL pc_inc3: got %h expected %h", pc, exp_val); end
        pc_read_en = 1'b0; rd_addr_a = 4'd0;
        #1;
        checks++;
        if (rd_data_a !== 32'd0 || pc !== 32'd28) begin
            errors++;
            $display("[TB] FAIL pc_mask_vs_pc: got rd=%h pc=%h expected 0 and %h", rd_data_a, pc, 32'd28);
        end
        pc_read_en = 1'b1;
    endtask

    task automatic test_dual_write();
        w1_en = 1'b1; w1_addr = 4'd5; w1_data = 32'h0000AAAA;
        w2_en = 1'b1; w2_addr = 4'd5; w2_data = 32'h00005555;
        exp_q.push_back(32'h00005555);
        step();
        idle_inputs();
        rd_addr_b = 4'd5;
        #1;
        exp_val = exp_q.pop_front();
        checks++;
        if (rd_data_b !== exp_val) begin errors++; $display("[TB] FAIL w2_priority: got %h expected %h", rd_data_b, exp_val); end
        checks++;
        if (wr_conflict !== 1'b0) begin errors++; $display("[TB] FAIL same_addr_no_conflict: got %b expected 0", wr_conflict); end
        w1_en = 1'b1; w1_addr = 4'd6; w1_data = 32'h66;
        w2_en = 1'b1; w2_addr = 4'd7; w2_data = 32'h77;
        exp_q.push_back(32'h66);
        exp_q.push_back(32'h77);
        step();
        idle_inputs();
        rd_addr_c = 4'd6; rd_addr_d = 4'd7;
        #1;
        exp_val = exp_q.pop_front();
        checks++;
        if (rd_data_c !== exp_val) begin errors++; $display("[TB] FAIL w1_write: got %h expected %h", rd_data_c, exp_val); end
        exp_val = exp_q.pop_front();
        checks++;
        if (rd_data_d !== exp_val) begin errors++; $display("[TB] FAIL w2_write: got %h expected %h", rd_data_d, exp_val); end
    endtask

    task automatic test_load();
        ld_issue = 1'b1; ld_dest = 4'd3; ld_addr = 32'h100;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_ready_idle: got %b expected 1", ld_ready); end
        step();
        ld_issue = 1'b0; ld_addr = 32'h0;
        rd_en = 4'b0001; rd_addr_a = 4'd3;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100 || stall !== 1'b1) begin
                errors++;
                $display("[TB] FAIL load_req_cycle%0d: got req=%b addr=%h stall=%b expected 1 00000100 1",
                         c, mem_req, mem_addr, stall);
            end
            if (c == 2) mem_gnt = 1'b1;
            step();
        end
        mem_gnt = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b1 || ld_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_wait: got req=%b stall=%b ld_ready=%b expected 0 1 0", mem_req, stall, ld_ready);
        end
        w1_en = 1'b1; w1_addr = 4'd3; w1_data = 32'h1234;
        step();
        w1_en = 1'b0;
        checks++;
        if (wr_conflict !== 1'b1) begin errors++; $display("[TB] FAIL conflict_pulse: got %b expected 1", wr_conflict); end
        step();
        checks++;
        if (wr_conflict !== 1'b0) begin errors++; $display("[TB] FAIL conflict_one_cycle: got %b expected 0", wr_conflict); end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        ld_issue = 1'b1; ld_dest = 4'd8; ld_addr = 32'h999;
        w1_en = 1'b1; w1_addr = 4'd3; w1_data = 32'h4321;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL completion_not_ready: got %b expected 0", ld_ready); end
        step();
        idle_inputs();
        rd_en = 4'b0001; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        #1;
        exp_val = exp_q.pop_front();
        checks++;
        if (rd_data_b !== exp_val) begin errors++; $display("[TB] FAIL load_data: got %h expected %h", rd_data_b, exp_val); end
        checks++;
        if (ld_ready !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_done_ctrl: got ld_ready=%b stall=%b req=%b expected 1 0 0", ld_ready, stall, mem_req);
        end
        checks++;
        if (wr_conflict !== 1'b1) begin errors++; $display("[TB] FAIL completion_conflict: got %b expected 1", wr_conflict); end
        rd_en = 4'b0000;
    endtask

    task automatic test_pc_wrap();
        w1_en = 1'b1; w1_addr = 4'd0; w1_data = 32'hFFFFFFFC; pc_inc = 1'b1;
        exp_q.push_back(32'hFFFFFFFC);
        step();
        w1_en = 1'b0;
        exp_val = exp_q.pop_front();
        checks++;
        if (pc !== exp_val) begin errors++; $display("[TB] FAIL pc_write_overrides_inc: got %h expected %h", pc, exp_val); end
        exp_q.push_back(32'h0);
        step();
        exp_val = exp_q.pop_front();
        checks++;
        if (pc !== exp_val) begin errors++; $display("[TB] FAIL pc_wrap: got %h expected %h", pc, exp_val); end
        w1_en = 1'b1; w1_addr = 4'd0; w1_data = 32'h40;
        exp_q.push_back(32'h40);
        step();
        idle_inputs();
        exp_val = exp_q.pop_front();
        checks++;
        if (pc !== exp_val) begin errors++; $display("[TB] FAIL pc_w1_vs_inc: got %h expected %h", pc, exp_val); end
    endtask

    task automatic test_back_to_back();
        ld_issue = 1'b1; ld_dest = 4'd9; ld_addr = 32'h200;
        step();
        ld_issue = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111;
        exp_q.push_back(32'h0);
        step();
        mem_rvalid = 1'b0;
        rd_addr_c = 4'd9;
        #1;
        exp_val = exp_q.pop_front();
        checks++;
        if (mem_req !== 1'b1 || rd_data_c !== exp_val) begin
            errors++;
            $display("[TB] FAIL rvalid_without_gnt: got req=%b reg9=%h expected 1 %h", mem_req, rd_data_c, exp_val);
        end
        rd_en = 4'b0100;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        exp_q.push_back(32'hCAFEF00D);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_port_c: got %b expected 1", stall); end
        step();
        idle_inputs();
        #1;
        exp_val = exp_q.pop_front();
        checks++;
        if (rd_data_c !== exp_val) begin errors++; $display("[TB] FAIL gnt_rvalid_data: got %h expected %h", rd_data_c, exp_val); end
        checks++;
        if (ld_ready !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gnt_rvalid_idle: got ld_ready=%b req=%b stall=%b expected 1 0 0", ld_ready, mem_req, stall);
        end
        ld_issue = 1'b1; ld_dest = 4'd0; ld_addr = 32'h400;
        step();
        ld_issue = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
            errors++;
            $display("[TB] FAIL reissue_req: got req=%b addr=%h expected 1 00000400", mem_req, mem_addr);
        end
        pc_inc = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000ABC0;
        exp_q.push_back(32'h0000ABC0);
        step();
        idle_inputs();
        exp_val = exp_q.pop_front();
        checks++;
        if (pc !== exp_val) begin errors++; $display("[TB] FAIL load_to_pc_overrides_inc: got %h expected %h", pc, exp_val); end
    endtask

    task automatic test_reset_mid_load();
        ld_issue = 1'b1; ld_dest = 4'd4; ld_addr = 32'h300;
        step();
        ld_issue = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rd_en = 4'b0001; rd_addr_a = 4'd4;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_wait: got req=%b stall=%b expected 0 1", mem_req, stall);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset: got req=%b stall=%b ld_ready=%b expected 0 0 1", mem_req, stall, ld_ready);
        end
        repeat (2) step();
        reset_n = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
        exp_q.push_back(32'h0);
        step();
        idle_inputs();
        rd_addr_b = 4'd4;
        #1;
        exp_val = exp_q.pop_front();
        checks++;
        if (rd_data_b !== exp_val) begin errors++; $display("[TB] FAIL late_rvalid_ignored: got %h expected %h", rd_data_b, exp_val); end
        checks++;
        if (pc !== 32'd16 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_state: got pc=%h req=%b expected %h 0", pc, mem_req, 32'd16);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_pc_inc();
        test_dual_write();
        test_load();
        test_pc_wrap();
        test_back_to_back();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
